// File: rtl/bip_report_decoder.sv
// rtl/bip_report_decoder.sv - parses "A:<n>\rC:<n>\r" ASCII reports and optionally sends the "s\r" run command
// The command sender is built only when START_CMD_EN is defined.
module bip_report_decoder #(
  parameter int MAX_DIGITS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_done_tick,
  input  logic [7:0]  rx_data,
  input  logic        start,
  input  logic        tx_done_tick,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic [15:0] acc_value,
  output logic [15:0] count_value,
  output logic        report_valid,
  output logic        frame_error,
  output logic        busy
);

  localparam logic [7:0] ASC_A     = 8'd65;
  localparam logic [7:0] ASC_C     = 8'd67;
  localparam logic [7:0] ASC_COLON = 8'd58;
  localparam logic [7:0] ASC_CR    = 8'd13;
  localparam logic [7:0] ASC_LF    = 8'd10;
  localparam logic [7:0] ASC_S     = 8'd115;
  localparam int         DIG_W     = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {IDLE, A_COLON, A_DIG, C_WAIT, C_COLON, C_DIG} parse_state_t;

  parse_state_t     state, state_next;
  logic [15:0]      acc_field, cnt_field;
  logic [DIG_W-1:0] digits;

  logic             is_digit, field_full, field_ovf;
  logic [15:0]      cur_field;
  logic [16:0]      field_next;
  logic             bad, clr_fields, set_err, clr_err, dig_en, dig_clr, load_out;
  logic             parse_busy, send_busy;

  assign is_digit   = (rx_data >= 8'd48) && (rx_data <= 8'd57);
  assign cur_field  = (state == C_DIG) ? cnt_field : acc_field;
  assign field_next = {1'b0, cur_field} * 17'd10 + {13'd0, rx_data[3:0]};
  assign field_full = (digits == DIG_W'(MAX_DIGITS));
  // The first term keeps the 17-bit product from wrapping if MAX_DIGITS is ever raised.
  assign field_ovf  = (cur_field > 16'd6553) || (field_next > 17'd65535);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    bad        = 1'b0;
    clr_fields = 1'b0;
    set_err    = 1'b0;
    clr_err    = 1'b0;
    dig_en     = 1'b0;
    dig_clr    = 1'b0;
    load_out   = 1'b0;
    if (rx_done_tick && (rx_data != ASC_LF)) begin
      if (rx_data == ASC_A) begin
        state_next = A_COLON;
        clr_fields = 1'b1;
        clr_err    = 1'b1;
      end else begin
        case (state)
          IDLE: ;
          A_COLON: begin
            if (rx_data == ASC_COLON) state_next = A_DIG;
            else                      bad = 1'b1;
          end
          C_WAIT: begin
            if (rx_data == ASC_C) state_next = C_COLON;
            else                  bad = 1'b1;
          end
          C_COLON: begin
            if (rx_data == ASC_COLON) state_next = C_DIG;
            else                      bad = 1'b1;
          end
          A_DIG, C_DIG: begin
            if (is_digit) begin
              if (field_full || field_ovf) bad = 1'b1;
              else                         dig_en = 1'b1;
            end else if (rx_data == ASC_CR) begin
              if (digits == '0) begin
                bad = 1'b1;
              end else if (state == A_DIG) begin
                state_next = C_WAIT;
                dig_clr    = 1'b1;
              end else begin
                state_next = IDLE;
                load_out   = 1'b1;
              end
            end else begin
              bad = 1'b1;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
    if (bad) begin
      state_next = IDLE;
      set_err    = 1'b1;
      clr_fields = 1'b1;
    end
  end

  always_comb begin
    parse_busy = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_field    <= '0;
      cnt_field    <= '0;
      digits       <= '0;
      acc_value    <= '0;
      count_value  <= '0;
      report_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      report_valid <= load_out;
      if (clr_fields) begin
        acc_field <= '0;
        cnt_field <= '0;
        digits    <= '0;
      end else if (dig_clr) begin
        digits <= '0;
      end else if (dig_en) begin
        digits <= digits + DIG_W'(1);
        if (state == A_DIG) acc_field <= field_next[15:0];
        else                cnt_field <= field_next[15:0];
      end
      if (load_out) begin
        acc_value   <= acc_field;
        count_value <= cnt_field;
      end
      if (set_err)      frame_error <= 1'b1;
      else if (clr_err) frame_error <= 1'b0;
    end
  end

`ifdef START_CMD_EN
  typedef enum logic [1:0] {C_IDLE, C_S, C_CR} send_state_t;

  send_state_t send_state, send_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) send_state <= C_IDLE;
    else       send_state <= send_next;
  end

  always_comb begin
    send_next = send_state;
    case (send_state)
      C_IDLE:  if (start)        send_next = C_S;
      C_S:     if (tx_done_tick) send_next = C_CR;
      C_CR:    if (tx_done_tick) send_next = C_IDLE;
      default: send_next = C_IDLE;
    endcase
  end

  always_comb begin
    tx_data   = 8'd0;
    tx_start  = 1'b0;
    send_busy = (send_state != C_IDLE);
    case (send_state)
      C_S: begin
        tx_data  = ASC_S;
        tx_start = 1'b1;
      end
      C_CR: begin
        tx_data  = ASC_CR;
        tx_start = 1'b1;
      end
      default: ;
    endcase
  end
`else
  logic unused_cmd_inputs;

  assign unused_cmd_inputs = start ^ tx_done_tick;
  assign tx_data           = 8'd0;
  assign tx_start          = 1'b0;
  assign send_busy         = 1'b0;
`endif

  assign busy = parse_busy | send_busy;

endmodule

// File: tb/tb_bip_report_decoder.sv
// tb/tb_bip_report_decoder.sv - randomized scoreboard bench for bip_report_decoder
module tb_bip_report_decoder;

  logic        clk = 1'b0;
  logic        reset, rx_done_tick, start, tx_done_tick;
  logic [7:0]  rx_data, tx_data;
  logic        tx_start, report_valid, frame_error, busy;
  logic [15:0] acc_value, count_value;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          model_acc = 0;
  int          model_cnt = 0;
  string       cr = "\015";
  string       lf = "\012";

  bip_report_decoder #(.MAX_DIGITS(5)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .start(start), .tx_done_tick(tx_done_tick), .tx_data(tx_data), .tx_start(tx_start),
    .acc_value(acc_value), .count_value(count_value), .report_valid(report_valid),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (report_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_report actual=%0d/%0d expected=none", acc_value, count_value);
      end else begin
        e = exp_q.pop_front();
        check("report_acc", int'(acc_value), int'(e[31:16]));
        check("report_cnt", int'(count_value), int'(e[15:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    rx_data      = 8'($urandom);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic send_str(input string s, input bit lf_noise);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
      if (lf_noise && (($urandom_range(0, 9) == 0) || (s[i] == 8'd13 && $urandom_range(0, 1) == 1)))
        send_byte(8'd10);
    end
  endtask

  task automatic after_checks(input bit exp_err, input string tag);
    check({tag, "_acc"}, int'(acc_value), model_acc);
    check({tag, "_cnt"}, int'(count_value), model_cnt);
    check({tag, "_err"}, int'(frame_error), int'(exp_err));
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // A good frame pushes its decoded pair; a bad one must leave the held values alone.
  task automatic frame_str(input string s, input bit ok, input int a, input int c, input bit lf_noise,
                           input string tag);
    if (ok) exp_q.push_back({a[15:0], c[15:0]});
    send_str(s, lf_noise);
    if (ok) begin
      model_acc = a;
      model_cnt = c;
    end
    after_checks(!ok, tag);
  endtask

  function automatic string rnum(input int v);
    string s;
    int    w;
    s = $sformatf("%0d", v);
    w = $urandom_range(s.len(), 5);
    while (s.len() < w) s = {"0", s};
    return s;
  endfunction

  function automatic string garbage();
    string s = "";
    int    b;
    repeat ($urandom_range(0, 3)) begin
      b = $urandom_range(32, 126);
      if (b == 65) b = 66;
      s = {s, $sformatf("%c", b)};
    end
    return s;
  endfunction

  task automatic bad_frame(input int kind);
    string s;
    string bads = "xBC;Z:D";
    string badw = "xBD;Z:0";
    int    v    = $urandom_range(65536, 99999);
    int    g    = $urandom_range(0, 65535);
    string b1   = $sformatf("%c", bads[$urandom_range(0, 6)]);
    string b2   = $sformatf("%c", badw[$urandom_range(0, 6)]);
    case (kind)
      0:       s = {"A:", $sformatf("%0d", v), cr, "C:1", cr};
      1:       s = {"A:1", cr, "C:", $sformatf("%0d", v), cr};
      2:       s = {"A:", $sformatf("%06d", g), cr, "C:1", cr};
      3:       s = {"A:", cr};
      4:       s = {"A:4", cr, "C:", cr};
      5:       s = {"A:1", b1, "2", cr, "C:3", cr};
      6:       s = {"A:5", cr, b2, ":3", cr};
      default: s = {"A5", cr};
    endcase
    frame_str({garbage(), s}, 1'b0, 0, 0, 1'b1, $sformatf("bad%0d", kind));
  endtask

  task automatic sender_test();
`ifdef START_CMD_EN
    fork
      begin
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("tx_s_start", int'(tx_start), 1);
        check("tx_s_data", int'(tx_data), 115);
        check("tx_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        check("tx_s_hold", int'(tx_data), 115);
        tx_done_tick = 1'b1;
        @(negedge clk) tx_done_tick = 1'b0;
        check("tx_cr_start", int'(tx_start), 1);
        check("tx_cr_data", int'(tx_data), 13);
        repeat (9) @(negedge clk);
        check("tx_cr_hold", int'(tx_start), 1);
        tx_done_tick = 1'b1;
        @(negedge clk) tx_done_tick = 1'b0;
        check("tx_end_start", int'(tx_start), 0);
        check("tx_end_data", int'(tx_data), 0);
        tx_done_tick = 1'b1;
        @(negedge clk) tx_done_tick = 1'b0;
        check("tx_idle_tick", int'(tx_start), 0);
      end
      begin
        exp_q.push_back({16'd77, 16'd88});
        send_str({"A:77", cr, "C:88", cr}, 1'b0);
        model_acc = 77;
        model_cnt = 88;
      end
    join
    repeat (2) @(negedge clk);
    after_checks(1'b0, "concurrent");
`else
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    tx_done_tick = 1'b1;
    check("nocmd_start", int'(tx_start), 0);
    check("nocmd_data", int'(tx_data), 0);
    check("nocmd_busy", int'(busy), 0);
    @(negedge clk) tx_done_tick = 1'b0;
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    string pre[7];
    int    k, a, c;
    pre[0] = "A"; pre[1] = "A:"; pre[2] = "A:12"; pre[3] = {"A:12", cr};
    pre[4] = {"A:12", cr, "C"}; pre[5] = {"A:12", cr, "C:"}; pre[6] = {"A:12", cr, "C:34"};

    reset = 1'b1; rx_done_tick = 1'b0; rx_data = 8'd0; start = 1'b0; tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_acc", int'(acc_value), 0);
    check("rst_cnt", int'(count_value), 0);
    check("rst_err", int'(frame_error), 0);
    check("rst_rv", int'(report_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_txs", int'(tx_start), 0);
    check("rst_txd", int'(tx_data), 0);
    reset = 1'b0;
    @(negedge clk);

    frame_str({"A:123", cr, "C:45", cr}, 1'b1, 123, 45, 1'b0, "basic");
    frame_str({"A:65535", cr, lf, "C:00007", cr}, 1'b1, 65535, 7, 1'b0, "max");
    frame_str({"A:65536", cr}, 1'b0, 0, 0, 1'b0, "ovf");
    send_str("A", 1'b0);
    check("err_clear_on_a", int'(frame_error), 0);
    check("busy_mid", int'(busy), 1);
    frame_str({":1", cr, "C:2", cr}, 1'b1, 1, 2, 1'b0, "after_err");
    frame_str({"A:12A:9", cr, "C:3", cr}, 1'b1, 9, 3, 1'b0, "restart");
    frame_str({"A:", cr}, 1'b0, 0, 0, 1'b0, "empty");
    frame_str({"A:000000", cr}, 1'b0, 0, 0, 1'b0, "six_digits");
    frame_str({"A:0", cr, "C:0", cr}, 1'b1, 0, 0, 1'b0, "zeros");

    frame_str({"A:7", cr, "C:8", cr}, 1'b1, 7, 8, 1'b0, "pre_reset");
    send_str("A:12", 1'b0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    model_acc = 0;
    model_cnt = 0;
    after_checks(1'b0, "mid_reset");
    frame_str({"A:5", cr, "C:6", cr}, 1'b1, 5, 6, 1'b0, "post_reset");

    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      a = $urandom_range(0, 65535);
      c = $urandom_range(0, 65535);
      if (k <= 4)
        frame_str({garbage(), "A:", rnum(a), cr, "C:", rnum(c), cr}, 1'b1, a, c, 1'b1, "rand_good");
      else if (k <= 7)
        bad_frame($urandom_range(0, 7));
      else
        frame_str({pre[$urandom_range(0, 6)], "A:", rnum(a), cr, "C:", rnum(c), cr}, 1'b1, a, c, 1'b1,
                  "rand_restart");
    end

    sender_test();

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
